// File: rtl/sram_arb_ctrl.sv
// Round-robin two-port arbiter and SETUP/ACCESS/HOLD sequencer for an external
// asynchronous 16-bit SRAM; every output comes straight from a register.
module sram_arb_ctrl #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        mclk,
   input  logic        puc_n,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [17:0] p0_addr,
   input  logic [15:0] p0_wdata,
   input  logic [1:0]  p0_be,
   output logic        p0_ack,
   output logic [15:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [17:0] p1_addr,
   input  logic [15:0] p1_wdata,
   input  logic [1:0]  p1_be,
   output logic        p1_ack,
   output logic [15:0] p1_rdata,
   output logic [17:0] sram_a,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n,
   output logic [15:0] sram_dout,
   output logic        sram_dout_en,
   input  logic [15:0] sram_din,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        cur_port, cur_port_nx;
   logic        cur_we, cur_we_nx;
   logic        last_grant, last_grant_nx;
   logic [17:0] sram_a_nx;
   logic        ce_n_nx, oe_n_nx, we_n_nx, ub_n_nx, lb_n_nx;
   logic [15:0] dout_nx;
   logic        dout_en_nx;
   logic        p0_ack_nx, p1_ack_nx;
   logic [15:0] p0_rdata_nx, p1_rdata_nx;
   logic        pick;
   logic        sel_we;
   logic [17:0] sel_addr;
   logic [15:0] sel_wdata;
   logic [1:0]  sel_be;

   // On a tie the port that did not win last time is served.
   always_comb begin
      pick      = (p0_req && p1_req) ? ~last_grant : p1_req;
      sel_we    = pick ? p1_we    : p0_we;
      sel_addr  = pick ? p1_addr  : p0_addr;
      sel_wdata = pick ? p1_wdata : p0_wdata;
      sel_be    = pick ? p1_be    : p0_be;
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      cur_port_nx   = cur_port;
      cur_we_nx     = cur_we;
      last_grant_nx = last_grant;
      sram_a_nx     = sram_a;
      ce_n_nx       = sram_ce_n;
      oe_n_nx       = sram_oe_n;
      we_n_nx       = sram_we_n;
      ub_n_nx       = sram_ub_n;
      lb_n_nx       = sram_lb_n;
      dout_nx       = sram_dout;
      dout_en_nx    = sram_dout_en;
      p0_ack_nx     = 1'b0;
      p1_ack_nx     = 1'b0;
      p0_rdata_nx   = p0_rdata;
      p1_rdata_nx   = p1_rdata;
      case (state)
         IDLE: begin
            if (p0_req || p1_req) begin
               state_nx      = SETUP;
               cnt_nx        = 4'(WAIT_CYCLES);
               cur_port_nx   = pick;
               cur_we_nx     = sel_we;
               last_grant_nx = pick;
               sram_a_nx     = sel_addr;
               ce_n_nx       = 1'b0;
               oe_n_nx       = 1'b1;
               we_n_nx       = 1'b1;
               ub_n_nx       = ~sel_be[1];
               lb_n_nx       = ~sel_be[0];
               if (sel_we) begin
                  dout_nx    = sel_wdata;
                  dout_en_nx = 1'b1;
               end
            end
         end
         SETUP: begin
            state_nx = ACCESS;
            if (cur_we) we_n_nx = 1'b0;
            else        oe_n_nx = 1'b0;
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               state_nx = HOLD;
               oe_n_nx  = 1'b1;
               we_n_nx  = 1'b1;
               if (cur_port) p1_ack_nx = 1'b1;
               else          p0_ack_nx = 1'b1;
               if (!cur_we) begin
                  if (cur_port) p1_rdata_nx = sram_din;
                  else          p0_rdata_nx = sram_din;
               end
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         HOLD: begin
            state_nx   = IDLE;
            ce_n_nx    = 1'b1;
            ub_n_nx    = 1'b1;
            lb_n_nx    = 1'b1;
            dout_en_nx = 1'b0;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!puc_n) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         cur_port     <= 1'b0;
         cur_we       <= 1'b0;
         last_grant   <= 1'b1;
         sram_a       <= 18'd0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_ub_n    <= 1'b1;
         sram_lb_n    <= 1'b1;
         sram_dout    <= 16'd0;
         sram_dout_en <= 1'b0;
         p0_ack       <= 1'b0;
         p1_ack       <= 1'b0;
         p0_rdata     <= 16'd0;
         p1_rdata     <= 16'd0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         cur_port     <= cur_port_nx;
         cur_we       <= cur_we_nx;
         last_grant   <= last_grant_nx;
         sram_a       <= sram_a_nx;
         sram_ce_n    <= ce_n_nx;
         sram_oe_n    <= oe_n_nx;
         sram_we_n    <= we_n_nx;
         sram_ub_n    <= ub_n_nx;
         sram_lb_n    <= lb_n_nx;
         sram_dout    <= dout_nx;
         sram_dout_en <= dout_en_nx;
         p0_ack       <= p0_ack_nx;
         p1_ack       <= p1_ack_nx;
         p0_rdata     <= p0_rdata_nx;
         p1_rdata     <= p1_rdata_nx;
         busy         <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl: default-timing instance with an SRAM model,
// plus WAIT_CYCLES=0 and WAIT_CYCLES=3 instances for strobe width and latency.
module tb_sram_arb_ctrl;

   logic        mclk;
   logic        puc_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [17:0] p0_addr, p1_addr;
   logic [15:0] p0_wdata, p1_wdata;
   logic [1:0]  p0_be, p1_be;
   logic        p0_ack, p1_ack;
   logic [15:0] p0_rdata, p1_rdata;
   logic [17:0] sram_a;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   logic [15:0] sram_dout, sram_din;
   logic        sram_dout_en, busy;

   logic        w0_req, w3_req;
   logic        w0_ack, w0_p1_ack, w0_ce_n, w0_oe_n, w0_we_n, w0_ub_n, w0_lb_n, w0_dout_en, w0_busy;
   logic [15:0] w0_rdata, w0_p1_rdata, w0_dout;
   logic [17:0] w0_a;
   logic        w3_ack, w3_p1_ack, w3_ce_n, w3_oe_n, w3_we_n, w3_ub_n, w3_lb_n, w3_dout_en, w3_busy;
   logic [15:0] w3_rdata, w3_p1_rdata, w3_dout;
   logic [17:0] w3_a;

   logic [15:0] mem [0:255];

   int          checks = 0;
   int          errors = 0;
   logic        prev_ce_n = 1'b1;
   logic [17:0] prev_a = '0;
   logic [15:0] prev_dout = '0;
   int          ack_cyc, strobe_cyc;
   logic        ub_seen, lb_seen;
   int          arb_cyc [4];
   logic        arb_port [4];

   sram_arb_ctrl #(.WAIT_CYCLES(1)) dut (
      .mclk(mclk), .puc_n(puc_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .sram_a(sram_a), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_dout(sram_dout),
      .sram_dout_en(sram_dout_en), .sram_din(sram_din), .busy(busy)
   );

   sram_arb_ctrl #(.WAIT_CYCLES(0)) dut_w0 (
      .mclk(mclk), .puc_n(puc_n),
      .p0_req(w0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ack(w0_ack), .p0_rdata(w0_rdata),
      .p1_req(1'b0), .p1_we(1'b0), .p1_addr(18'd0), .p1_wdata(16'd0), .p1_be(2'b00),
      .p1_ack(w0_p1_ack), .p1_rdata(w0_p1_rdata),
      .sram_a(w0_a), .sram_ce_n(w0_ce_n), .sram_oe_n(w0_oe_n), .sram_we_n(w0_we_n),
      .sram_ub_n(w0_ub_n), .sram_lb_n(w0_lb_n), .sram_dout(w0_dout),
      .sram_dout_en(w0_dout_en), .sram_din(16'd0), .busy(w0_busy)
   );

   sram_arb_ctrl #(.WAIT_CYCLES(3)) dut_w3 (
      .mclk(mclk), .puc_n(puc_n),
      .p0_req(w3_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ack(w3_ack), .p0_rdata(w3_rdata),
      .p1_req(1'b0), .p1_we(1'b0), .p1_addr(18'd0), .p1_wdata(16'd0), .p1_be(2'b00),
      .p1_ack(w3_p1_ack), .p1_rdata(w3_p1_rdata),
      .sram_a(w3_a), .sram_ce_n(w3_ce_n), .sram_oe_n(w3_oe_n), .sram_we_n(w3_we_n),
      .sram_ub_n(w3_ub_n), .sram_lb_n(w3_lb_n), .sram_dout(w3_dout),
      .sram_dout_en(w3_dout_en), .sram_din(16'd0), .busy(w3_busy)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Asynchronous SRAM model: byte-lane writes while CE and WE are low, reads while CE and OE are low.
   always @(posedge mclk) begin
      if (!sram_ce_n && !sram_we_n && sram_dout_en) begin
         if (!sram_ub_n) mem[sram_a[7:0]][15:8] <= sram_dout[15:8];
         if (!sram_lb_n) mem[sram_a[7:0]][7:0]  <= sram_dout[7:0];
      end
   end
   assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[7:0]] : 16'hDEAD;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkInvariants();
      checkOutput("no_we_oe_overlap", 32'(!sram_we_n && !sram_oe_n), 32'd0);
      checkOutput("no_drive_during_oe", 32'(sram_dout_en && !sram_oe_n), 32'd0);
      if (!prev_ce_n && !sram_ce_n) begin
         checkOutput("addr_stable", 32'(sram_a), 32'(prev_a));
         checkOutput("dout_stable", 32'(sram_dout), 32'(prev_dout));
      end
      prev_ce_n = sram_ce_n;
      prev_a    = sram_a;
      prev_dout = sram_dout;
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
      checkInvariants();
   endtask

   // Runs one transaction on instance inst (0=default, 1=WAIT_CYCLES 0, 2=WAIT_CYCLES 3) from an IDLE cycle.
   task automatic applyStimulus(input int inst, input logic port, input logic we, input logic [17:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be);
      int   cyc;
      logic ack, strobe, ub, lb;
      if (port) begin p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be; end
      else      begin p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be; end
      case (inst)
         0:       if (port) p1_req = 1'b1; else p0_req = 1'b1;
         1:       w0_req = 1'b1;
         default: w3_req = 1'b1;
      endcase
      cyc = 0; ack_cyc = -1; strobe_cyc = 0; ub_seen = 1'bx; lb_seen = 1'bx;
      while (cyc < 30 && ack_cyc < 0) begin
         tick();
         cyc++;
         case (inst)
            0: begin ack = port ? p1_ack : p0_ack; strobe = !sram_we_n || !sram_oe_n; ub = sram_ub_n; lb = sram_lb_n; end
            1: begin ack = w0_ack; strobe = !w0_we_n || !w0_oe_n; ub = w0_ub_n; lb = w0_lb_n; end
            default: begin ack = w3_ack; strobe = !w3_we_n || !w3_oe_n; ub = w3_ub_n; lb = w3_lb_n; end
         endcase
         if (strobe) strobe_cyc++;
         if (cyc == 1) begin ub_seen = ub; lb_seen = lb; end
         if (ack) ack_cyc = cyc;
      end
      p0_req = 1'b0; p1_req = 1'b0; w0_req = 1'b0; w3_req = 1'b0;
      if (ack_cyc >= 0) tick();
   endtask

   // Both ports request continuously; records which port acks on which cycle.
   task automatic arbRun(input int n_acks);
      int cyc, k;
      cyc = 0; k = 0;
      for (int i = 0; i < 4; i++) begin arb_cyc[i] = -1; arb_port[i] = 1'bx; end
      p0_req = 1'b1; p1_req = 1'b1;
      while (cyc < 60 && k < n_acks) begin
         tick();
         cyc++;
         if (p0_ack) begin arb_cyc[k] = cyc; arb_port[k] = 1'b0; k++; end
         else if (p1_ack) begin arb_cyc[k] = cyc; arb_port[k] = 1'b1; k++; end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      tick();
   endtask

   initial begin
      puc_n = 1'b0;
      p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
      p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
      w0_req = 0; w3_req = 0;
      repeat (3) tick();
      checkOutput("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
      checkOutput("rst_misc", {28'd0, sram_dout_en, busy, p0_ack, p1_ack}, 32'h0);
      checkOutput("rst_addr", 32'(sram_a), 32'h0);
      checkOutput("rst_dout", 32'(sram_dout), 32'h0);
      checkOutput("rst_rdata", {p0_rdata, p1_rdata}, 32'h0);
      puc_n = 1'b1;
      tick();

      $display("[TB] arbitration after reset");
      p0_we = 1; p0_addr = 18'h00020; p0_wdata = 16'h1111; p0_be = 2'b11;
      p1_we = 1; p1_addr = 18'h00021; p1_wdata = 16'h2222; p1_be = 2'b11;
      arbRun(4);
      checkOutput("arb0", {arb_cyc[0][30:0], arb_port[0]}, {31'd4, 1'b0});
      checkOutput("arb1", {arb_cyc[1][30:0], arb_port[1]}, {31'd9, 1'b1});
      checkOutput("arb2", {arb_cyc[2][30:0], arb_port[2]}, {31'd14, 1'b0});
      checkOutput("arb3", {arb_cyc[3][30:0], arb_port[3]}, {31'd19, 1'b1});

      $display("[TB] p0 full write and readback");
      applyStimulus(0, 1'b0, 1'b1, 18'h00010, 16'hA55A, 2'b11);
      checkOutput("wr_ack_cycle", 32'(ack_cyc), 32'd4);
      checkOutput("wr_strobe", 32'(strobe_cyc), 32'd2);
      checkOutput("wr_be_lanes", {30'd0, ub_seen, lb_seen}, 32'd0);
      checkOutput("post_hold", {29'd0, sram_ce_n, sram_dout_en, busy}, 32'h4);
      applyStimulus(0, 1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11);
      checkOutput("rd_ack_cycle", 32'(ack_cyc), 32'd4);
      checkOutput("rd_strobe", 32'(strobe_cyc), 32'd2);
      checkOutput("rd_p0_data", 32'(p0_rdata), 32'hA55A);

      $display("[TB] p1 byte writes");
      applyStimulus(0, 1'b1, 1'b1, 18'h00034, 16'h3434, 2'b11);
      applyStimulus(0, 1'b1, 1'b1, 18'h00034, 16'h12FF, 2'b10);
      checkOutput("bw_lanes", {30'd0, ub_seen, lb_seen}, 32'd1);
      applyStimulus(0, 1'b1, 1'b0, 18'h00034, 16'h0000, 2'b11);
      checkOutput("bw_readback", 32'(p1_rdata), 32'h1234);
      applyStimulus(0, 1'b1, 1'b1, 18'h00034, 16'hFFFF, 2'b00);
      checkOutput("be00_ack_cycle", 32'(ack_cyc), 32'd4);
      checkOutput("be00_lanes", {30'd0, ub_seen, lb_seen}, 32'd3);
      applyStimulus(0, 1'b1, 1'b0, 18'h00034, 16'h0000, 2'b11);
      checkOutput("be00_readback", 32'(p1_rdata), 32'h1234);
      checkOutput("p0_rdata_kept", 32'(p0_rdata), 32'hA55A);

      $display("[TB] wait-state variants");
      applyStimulus(1, 1'b0, 1'b1, 18'h00040, 16'h5555, 2'b11);
      checkOutput("w0_ack_cycle", 32'(ack_cyc), 32'd3);
      checkOutput("w0_strobe", 32'(strobe_cyc), 32'd1);
      applyStimulus(2, 1'b0, 1'b1, 18'h00040, 16'h5555, 2'b11);
      checkOutput("w3_ack_cycle", 32'(ack_cyc), 32'd6);
      checkOutput("w3_strobe", 32'(strobe_cyc), 32'd4);

      $display("[TB] reset during write access");
      p0_we = 1; p0_addr = 18'h00050; p0_wdata = 16'hBEEF; p0_be = 2'b11;
      p0_req = 1'b1;
      tick();
      tick();
      checkOutput("mid_we_low", 32'(sram_we_n), 32'd0);
      puc_n = 1'b0; p0_req = 1'b0;
      tick();
      checkOutput("mid_rst_pins", {28'd0, sram_we_n, sram_ce_n, sram_dout_en, busy}, 32'hC);
      checkOutput("mid_rst_rdata", {p0_rdata, p1_rdata}, 32'h0);
      puc_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("mid_no_ack", {30'd0, p0_ack, p1_ack}, 32'd0);
      end
      p0_we = 0; p0_addr = 18'h00020;
      p1_we = 0; p1_addr = 18'h00021;
      arbRun(2);
      checkOutput("post_rst_arb0", {arb_cyc[0][30:0], arb_port[0]}, {31'd4, 1'b0});
      checkOutput("post_rst_arb1", {arb_cyc[1][30:0], arb_port[1]}, {31'd9, 1'b1});
      checkOutput("post_rst_rdata", {p0_rdata, p1_rdata}, 32'h1111_2222);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
